lutram_stream_reader: RTL and testbench

LUTRAM_STREAM_READER -- requirements
Module: lutram_stream_reader

---
 rtl/lutram_rd_pkg.sv | 16 +
 rtl/lutram_bit_packer.sv | 48 ++++
 rtl/lutram_stream_reader.sv | 131 +++++++++++++
 tb/tb_lutram_stream_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lutram_rd_pkg.sv
// Shared types and constants for the LUT-RAM bit-stream reader.
package lutram_rd_pkg;

    localparam int ADDR_W    = 7;
    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 16;
    localparam int BCNT_W    = $clog2(MAX_BYTES);
    localparam int BIT_W     = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_e;

endpackage

// File: rtl/lutram_bit_packer.sv
// Collects eight 1-bit RAM samples into a byte, in LSB-first or MSB-first placement.
module lutram_bit_packer
    import lutram_rd_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              sample_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              byte_cmpl_o
);

    logic [BYTE_W-1:0] data_q, data_d;
    logic [BIT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  pos;

    // MSB-first simply mirrors the bit index within the byte.
    assign pos = MSB_FIRST ? ~cnt_q : cnt_q;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            data_d[pos] = bit_i;
            cnt_d       = cnt_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o      = data_q;
    // High while the sample being taken is the last one of the byte.
    assign byte_cmpl_o = (cnt_q == BIT_W'(BYTE_W - 1));

endmodule

// File: rtl/lutram_stream_reader.sv
// Streams NUM_BYTES bytes out of a 128x1 async LUT RAM; optional M_PARITY when LUTRAM_RD_PARITY_EN is defined.
module lutram_stream_reader
    import lutram_rd_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] A,
    input  logic              O,
    output logic              BUSY,
    output logic              DONE,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [BYTE_W-1:0] M_DATA,
    output logic              M_LAST
`ifdef LUTRAM_RD_PARITY_EN
    ,
    output logic              M_PARITY
`endif
);

    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(NUM_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                done_q, done_d;
    logic                sample;
    logic                clr;
    logic                byte_cmpl;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        sample  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                bcnt_d = '0;
                clr    = 1'b1;
                if (START && !ABORT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (ABORT) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    clr     = 1'b1;
                end else begin
                    sample = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (byte_cmpl) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                // Abort wins over a handshake in the same cycle.
                if (ABORT) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    clr     = 1'b1;
                end else if (M_READY) begin
                    if (bcnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        bcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                bcnt_d  = '0;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
        end
    end

    lutram_bit_packer #(
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk_i       (CLK),
        .rst_n_i     (RST_N),
        .clr_i       (clr),
        .sample_i    (sample),
        .bit_i       (O),
        .data_o      (M_DATA),
        .byte_cmpl_o (byte_cmpl)
    );

    assign A       = addr_q;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign M_VALID = (state_q == SEND);
    assign M_LAST  = (state_q == SEND) && (bcnt_q == LAST_IDX);

`ifdef LUTRAM_RD_PARITY_EN
    // Derived from the registered byte, so it moves only when M_DATA does.
    assign M_PARITY = ^M_DATA;
`endif

endmodule

// File: tb/tb_lutram_stream_reader.sv
// Directed bench for lutram_stream_reader: LSB-first 16-byte and MSB-first 2-byte instances.
module tb_lutram_stream_reader;

    localparam logic [127:0] RAM = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, m_ready;
    logic [6:0] a;
    logic       o, busy, done, m_valid, m_last;
    logic [7:0] m_data;
    logic       start2;
    logic [6:0] a2;
    logic       o2, busy2, done2, mv2, ml2;
    logic [7:0] md2;
`ifdef LUTRAM_RD_PARITY_EN
    logic       m_parity, mp2;
`endif

    logic [7:0] exp16 [16] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
                               8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] exp2 [2]   = '{8'h08, 8'h4C};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign o  = RAM[a];
    assign o2 = RAM[a2];

    lutram_stream_reader #(.NUM_BYTES(16), .MSB_FIRST(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .A(a), .O(o),
        .BUSY(busy), .DONE(done), .M_VALID(m_valid), .M_READY(m_ready),
        .M_DATA(m_data), .M_LAST(m_last)
`ifdef LUTRAM_RD_PARITY_EN
        , .M_PARITY(m_parity)
`endif
    );

    lutram_stream_reader #(.NUM_BYTES(2), .MSB_FIRST(1'b1)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .ABORT(1'b0), .A(a2), .O(o2),
        .BUSY(busy2), .DONE(done2), .M_VALID(mv2), .M_READY(1'b1),
        .M_DATA(md2), .M_LAST(ml2)
`ifdef LUTRAM_RD_PARITY_EN
        , .M_PARITY(mp2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_seen", 32'(m_valid), 32'd1);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  32'(busy),    32'd0);
        check({tag, "_done"},  32'(done),    32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_data"},  32'(m_data),  32'h00);
        check({tag, "_last"},  32'(m_last),  32'd0);
        check({tag, "_addr"},  32'(a),       32'd0);
`ifdef LUTRAM_RD_PARITY_EN
        check({tag, "_par"},   32'(m_parity), 32'd0);
`endif
    endtask

    // Full 16-byte stream with M_READY high; lat0 is ticks from here to the first valid.
    task automatic stream16(input int lat0);
        int n;
        for (int i = 0; i < 16; i++) begin
            wait_valid(40, n);
            check("byte_lat",  32'(n),      32'((i == 0) ? lat0 : 8));
            check("byte_data", 32'(m_data), 32'(exp16[i]));
            check("byte_last", 32'(m_last), 32'(i == 15));
`ifdef LUTRAM_RD_PARITY_EN
            check("byte_par",  32'(m_parity), 32'(^exp16[i]));
`endif
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy",  32'(busy), 32'd0);
        check("done_addr",  32'(a),    32'd0);
        tick();
        check("done_once",  32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1; start2 = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // 16-byte LSB-first run, first valid in cycle 9
        start_run();
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_a0",   32'(a),    32'd0);
        stream16(8);

        // MSB-first, 2 bytes
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!mv2 && n < 40) begin
                tick();
                n++;
            end
            check("msb_valid", 32'(mv2), 32'd1);
            check("msb_lat",   32'(n),   32'd8);
            check("msb_data",  32'(md2), 32'(exp2[i]));
            check("msb_last",  32'(ml2), 32'(i == 1));
            tick();
        end
        check("msb_done",  32'(done2), 32'd1);
        check("msb_busy",  32'(busy2), 32'd0);
        check("msb_addr",  32'(a2),    32'd0);

        // Back-pressure on byte 0
        m_ready = 1'b0;
        start_run();
        wait_valid(40, n);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data",  32'(m_data),  32'h10);
            check("stall_addr",  32'(a),       32'd8);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("resume_fetch", 32'(m_valid), 32'd0);
        wait_valid(40, n);
        check("resume_data", 32'(m_data), 32'h32);
        // Abort together with a handshake
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hs_busy",  32'(busy),    32'd0);
        check("abort_hs_done",  32'(done),    32'd0);
        check("abort_hs_valid", 32'(m_valid), 32'd0);
        check("abort_hs_addr",  32'(a),       32'd0);

        // Abort during FETCH of byte 3
        start_run();
        for (int i = 0; i < 3; i++) begin
            wait_valid(40, n);
            check("pre_abort_data", 32'(m_data), 32'(exp16[i]));
            tick();
        end
        repeat (3) tick();
        check("abort_in_fetch", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy),    32'd0);
        check("abort_done", 32'(done),    32'd0);
        check("abort_addr", 32'(a),       32'd0);
        tick();
        check("abort_nodone", 32'(done),  32'd0);
        start_run();
        wait_valid(40, n);
        check("restart_lat",  32'(n),      32'd8);
        check("restart_data", 32'(m_data), 32'h10);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset during SEND of byte 5
        start_run();
        for (int i = 0; i < 5; i++) begin
            wait_valid(40, n);
            tick();
        end
        m_ready = 1'b0;
        wait_valid(40, n);
        check("b5_data", 32'(m_data), 32'hBA);
        rst_n = 1'b0;
        tick();
        check_reset("midrst");
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        check("midrst_nodone", 32'(done), 32'd0);

        // START with ABORT in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);

        // START while busy is neither restarted nor queued
        start_run();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_addr", 32'(a), 32'd4);
        stream16(4);
        repeat (12) tick();
        check("no_queue_busy",  32'(busy),    32'd0);
        check("no_queue_valid", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
